// File: rtl/ppg_seq_pkg.sv
// Shared definitions for the PPG slot sequencer: state codes, idle front-end
// settings and small helpers used by the sequencer datapath.
package ppg_seq_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE       = 3'd0;
    localparam seq_state_t ST_RED_SETTLE = 3'd1;
    localparam seq_state_t ST_RED_ACQ    = 3'd2;
    localparam seq_state_t ST_IR_SETTLE  = 3'd3;
    localparam seq_state_t ST_IR_ACQ     = 3'd4;
    localparam seq_state_t ST_AMB_SETTLE = 3'd5;
    localparam seq_state_t ST_AMB_ACQ    = 3'd6;

    localparam logic [6:0] DC_COMP_IDLE = 7'd64;
    localparam logic [3:0] PGA_IDLE     = 4'd0;

    // Width of a counter spanning one slot (settle cycles plus averaged samples)
    function automatic int slot_cnt_width(input int settle_cyc, input int avg_log2);
        int len;
        len = settle_cyc + (1 << avg_log2);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/ppg_slot_accum.sv
// Per-slot ADC accumulator; avg includes the sample present this cycle so the
// slot result is ready on the same edge that closes the slot.
module ppg_slot_accum #(
    parameter int AVG_LOG2 = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       acc_en,
    input  logic [7:0] adc,
    output logic [7:0] avg
);

    localparam int ACC_W = 8 + AVG_LOG2;

    logic [ACC_W-1:0] acc;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(adc);
        end
    end

    assign avg = 8'((acc + ACC_W'(adc)) >> AVG_LOG2);

endmodule

// File: rtl/ppg_slot_sequencer.sv
// Time-multiplexed LED/front-end scheduler producing one RED/IR average pair per frame.
// Optional ambient slot with ambient subtraction: define PPG_AMBIENT_SLOT_EN.
module ppg_slot_sequencer
    import ppg_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 6,
    parameter int AVG_LOG2   = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] red_dc_comp,
    input  logic [6:0] ir_dc_comp,
    input  logic [3:0] red_pga,
    input  logic [3:0] ir_pga,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic       pair_valid,
    input  logic       pair_ready,
    output logic       overrun
);

    localparam int SLOT_LEN = SETTLE_CYC + (1 << AVG_LOG2);
    localparam int CW       = slot_cnt_width(SETTLE_CYC, AVG_LOG2);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST   = CW'(SLOT_LEN - 1);
`ifdef PPG_AMBIENT_SLOT_EN
    localparam seq_state_t LAST_ACQ = ST_AMB_ACQ;
`else
    localparam seq_state_t LAST_ACQ = ST_IR_ACQ;
`endif

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          in_acq;
    logic          slot_end;
    logic          red_end;
    logic          frame_end;
    logic          frame_start;
    logic [6:0]    ir_dc_lat;
    logic [3:0]    ir_pga_lat;
    logic [7:0]    acc_avg;
    logic [7:0]    red_avg;
    logic [7:0]    red_res;
    logic [7:0]    ir_res;
    logic          acc_clear;

    always_comb begin
        in_acq = (state == ST_RED_ACQ) || (state == ST_IR_ACQ);
`ifdef PPG_AMBIENT_SLOT_EN
        in_acq = in_acq || (state == ST_AMB_ACQ);
`endif
        slot_end    = in_acq && (cnt == SLOT_LAST);
        red_end     = enable && slot_end && (state == ST_RED_ACQ);
        frame_end   = enable && slot_end && (state == LAST_ACQ);
        frame_start = enable && ((state == ST_IDLE) || frame_end);
        acc_clear   = !enable || (state == ST_IDLE) || slot_end;
    end

    // The slot counter is the only timer; it restarts at every slot boundary
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_RED_SETTLE;
                    cnt_nxt   = '0;
                end
                ST_RED_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_RED_ACQ;
                ST_RED_ACQ: if (slot_end) begin
                    state_nxt = ST_IR_SETTLE;
                    cnt_nxt   = '0;
                end
                ST_IR_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_IR_ACQ;
                ST_IR_ACQ: if (slot_end) begin
`ifdef PPG_AMBIENT_SLOT_EN
                    state_nxt = ST_AMB_SETTLE;
`else
                    state_nxt = ST_RED_SETTLE;
`endif
                    cnt_nxt   = '0;
                end
`ifdef PPG_AMBIENT_SLOT_EN
                ST_AMB_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_AMB_ACQ;
                ST_AMB_ACQ: if (slot_end) begin
                    state_nxt = ST_RED_SETTLE;
                    cnt_nxt   = '0;
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // LEDs and analogue settings derive from the next state so they switch together
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            LED_RED    <= 1'b0;
            LED_IR     <= 1'b0;
            DC_Comp    <= DC_COMP_IDLE;
            PGA_Gain   <= PGA_IDLE;
            ir_dc_lat  <= '0;
            ir_pga_lat <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            LED_RED <= (state_nxt == ST_RED_SETTLE) || (state_nxt == ST_RED_ACQ);
            LED_IR  <= (state_nxt == ST_IR_SETTLE) || (state_nxt == ST_IR_ACQ);
            if (!enable) begin
                DC_Comp  <= DC_COMP_IDLE;
                PGA_Gain <= PGA_IDLE;
            end else if (frame_start) begin
                DC_Comp    <= red_dc_comp;
                PGA_Gain   <= red_pga;
                ir_dc_lat  <= ir_dc_comp;
                ir_pga_lat <= ir_pga;
            end else if (red_end) begin
                DC_Comp  <= ir_dc_lat;
                PGA_Gain <= ir_pga_lat;
            end
        end
    end

    ppg_slot_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .acc_en (in_acq),
        .adc    (ADC),
        .avg    (acc_avg)
    );

`ifdef PPG_AMBIENT_SLOT_EN
    logic [7:0] ir_avg;
    logic [7:0] amb_avg;

    // Ambient is applied one frame late; the new value is stored after use
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ir_avg  <= '0;
            amb_avg <= '0;
        end else if (!enable) begin
            amb_avg <= '0;
        end else begin
            if (slot_end && (state == ST_IR_ACQ)) ir_avg <= acc_avg;
            if (frame_end) amb_avg <= acc_avg;
        end
    end

    assign red_res = sat_sub(red_avg, amb_avg);
    assign ir_res  = sat_sub(ir_avg, amb_avg);
`else
    assign red_res = red_avg;
    assign ir_res  = acc_avg;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            red_avg       <= '0;
            RED_ADC_Value <= '0;
            IR_ADC_Value  <= '0;
            pair_valid    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (red_end) red_avg <= acc_avg;
            if (!enable) overrun <= 1'b0;
            if (frame_end) begin
                RED_ADC_Value <= red_res;
                IR_ADC_Value  <= ir_res;
                pair_valid    <= 1'b1;
                if (pair_valid && !pair_ready) overrun <= 1'b1;
            end else if (pair_valid && pair_ready) begin
                pair_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ppg_slot_sequencer.md
# ppg_slot_sequencer

Time-multiplexing scheduler for the shared photodiode front end: PGA, DC compensation DAC and 8-bit ADC. It runs after calibration has produced per-LED DC_Comp/PGA settings. Each frame it drives one LED per slot, loads that slot's analogue settings, discards samples while the analogue path settles, then averages 2^AVG_LOG2 ADC samples. One RED/IR result pair per frame goes to the SpO2 datapath over a valid/ready handshake.

## Interface
- SETTLE_CYC, 6, cycles per slot with ADC ignored (range 1..15)
- AVG_LOG2, 2, log2 of samples averaged per slot (range 0..3)
- CLK  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run sequencing; low forces IDLE
- red_dc_comp / ir_dc_comp  in  7  calibrated DC compensation per LED
- red_pga / ir_pga  in  4  calibrated PGA gain per LED
- ADC  in  8  front-end ADC sample, valid every cycle
- LED_RED / LED_IR  out  1  LED enables, never both high
- DC_Comp  out  7  DC compensation DAC code
- PGA_Gain  out  4  PGA gain code
- RED_ADC_Value / IR_ADC_Value  out  8  averaged results of the last completed frame
- pair_valid  out  1  result pair available
- pair_ready  in  1  consumer accepts pair
- overrun  out  1  sticky: unaccepted pair overwritten

## Operation
- States: IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ (plus AMB_SETTLE, AMB_ACQ under macro).
- Slot length L = SETTLE_CYC + 2^AVG_LOG2. The slot counter runs 0..L-1 and is the only timer.
- IDLE → RED_SETTLE on an edge sampling enable=1. red/ir settings are latched there and at every frame start (RED_SETTLE entry). Changes mid-frame take effect next frame.
- X_SETTLE → X_ACQ at counter SETTLE_CYC-1. X_ACQ → next slot at counter L-1.
- Slot order: RED → IR → RED (macro off); RED → IR → AMB → RED (macro on).
- LED_RED is high in RED_* only. LED_IR is high in IR_* only. Both LEDs are low in IDLE and AMB_*.
- DC_Comp/PGA_Gain are registered and switch on the same edge as the LEDs. AMB_* uses the IR settings.
- ACQ: accumulator (8+AVG_LOG2 bits) adds ADC each cycle. It clears at slot entry.
- Average = acc >> AVG_LOG2, truncating, no rounding.
- The RED average registers internally at the end of the RED slot.
- At the end of the last slot of the frame, RED_ADC_Value/IR_ADC_Value update together and pair_valid is set.
- Handshake: pair_valid stays high until sampled with pair_ready=1, then clears.
- If a new pair completes while pair_valid=1 and pair_ready=0: values are overwritten, pair_valid stays 1, and overrun sets.
- Completion coincident with pair_ready=1: no overrun, pair_valid stays 1 with new data.
- enable low in any state: next edge goes to IDLE, LEDs go off, DC_Comp=64, PGA_Gain=0. The partial frame is discarded, with no pair emitted. Result registers and pair_valid hold. overrun clears.

## Timing
- Reset values:
  - state IDLE
  - LED_RED=0, LED_IR=0
  - DC_Comp=64, PGA_Gain=0
  - RED_ADC_Value=0, IR_ADC_Value=0
  - pair_valid=0, overrun=0
- Edge 0 samples enable=1. Defaults give L=10.
- Edge 0: LED_RED=1, red settings applied.
- RED ADC samples are taken at edges 7..10.
- Edge 10: LED_RED=0, LED_IR=1.
- IR ADC samples are taken at edges 17..20.
- Edge 20: IR_ADC_Value/RED_ADC_Value update, pair_valid=1, LED_RED=1.
- Frame period: 2L cycles (3L with macro).
- LED switching is break-free: both LEDs change on the same edge. No cycle exists with both LEDs high.

## Configuration
- PPG_AMBIENT_SLOT_EN defined:
  - adds the AMB slot (LEDs off) after IR.
  - The ambient average is stored at the end of the AMB slot.
  - RED/IR results become max(avg − ambient, 0), using the ambient from the previous frame. Ambient is 0 after reset/IDLE.
  - pair_valid asserts at the end of the AMB slot.
- PPG_AMBIENT_SLOT_EN undefined: two-slot frame, raw averages, no ambient storage.

## Structure
- Package ppg_seq_pkg:
  - state enum
  - DC_COMP_IDLE=64, PGA_IDLE=0
  - slot-counter width function
- Sub-module ppg_slot_accum:
  - clear/accumulate/average per slot
  - parameterised by AVG_LOG2
  - instantiated once, since slots are serial.

## Test plan
- ADC=100 in RED slot, 200 in IR slot, pair_ready=1 → edge 20: RED_ADC_Value=100, IR_ADC_Value=200, pair_valid one cycle.
- ADC=255 in settle cycles, 10,11,12,13 in RED ACQ → RED_ADC_Value=11 (46>>2).
- pair_ready=0 for two frames → overrun=1 at edge 40, values from frame 2; drop enable → overrun=0.
- enable low at edge 15 (IR_SETTLE) → edge 16: LEDs 0, DC_Comp=64, PGA_Gain=0, no pair_valid; re-enable restarts with RED.
- red_pga changed from 3 to 7 at edge 5 → PGA_Gain=3 in current frame, 7 from next frame's RED slot.
- Macro on: ambient ADC=30, RED=100, IR=20 → second frame RED=70, IR=0; first frame RED=100.
